// File: rtl/axil_reg_bridge.sv
// axil_reg_bridge: AXI4-Lite slave driving a single-cycle register port.
// Ports: clk/rst, s_axil_* AXI-Lite slave, reg_* register port; macro AXIL_ADDR_CHECK_EN.
//
// Port summary
//   clk, rst            : clock, synchronous active-high reset
//   s_axil_aw*/w*/b*    : AXI-Lite write address, data and response channels
//   s_axil_ar*/r*       : AXI-Lite read address and data channels
//   reg_wr_en/addr/data : one-cycle register write strobe, word index, data
//   reg_rd_en/addr      : one-cycle register read strobe, word index
//   reg_rd_data         : read data, valid one clock after reg_rd_en
//
// Build option
//   AXIL_ADDR_CHECK_EN  : word indices >= NUM_REGS get no strobe and
//                         answer SLVERR (reads return zero data).
module axil_reg_bridge #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS       = 8
) (
  input  logic                        clk,
  input  logic                        rst,

  input  logic [AXI_ADDR_WIDTH-1:0]   s_axil_awaddr,
  input  logic                        s_axil_awvalid,
  output logic                        s_axil_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axil_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axil_wstrb,
  input  logic                        s_axil_wvalid,
  output logic                        s_axil_wready,
  output logic [1:0]                  s_axil_bresp,
  output logic                        s_axil_bvalid,
  input  logic                        s_axil_bready,

  input  logic [AXI_ADDR_WIDTH-1:0]   s_axil_araddr,
  input  logic                        s_axil_arvalid,
  output logic                        s_axil_arready,
  output logic [AXI_DATA_WIDTH-1:0]   s_axil_rdata,
  output logic [1:0]                  s_axil_rresp,
  output logic                        s_axil_rvalid,
  input  logic                        s_axil_rready,

  output logic                        reg_wr_en,
  output logic [AXI_ADDR_WIDTH-1:0]   reg_wr_addr,
  output logic [AXI_DATA_WIDTH-1:0]   reg_wr_data,
  output logic                        reg_rd_en,
  output logic [AXI_ADDR_WIDTH-1:0]   reg_rd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   reg_rd_data
);

  localparam int ADDR_LSB = $clog2(AXI_DATA_WIDTH / 8);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] W_COLLECT = 2'd0;
  localparam logic [1:0] W_ISSUE   = 2'd1;
  localparam logic [1:0] W_RESP    = 2'd2;

  localparam logic [1:0] R_IDLE    = 2'd0;
  localparam logic [1:0] R_ISSUE   = 2'd1;
  localparam logic [1:0] R_CAPTURE = 2'd2;
  localparam logic [1:0] R_RESP    = 2'd3;

`ifdef AXIL_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  localparam logic [AXI_ADDR_WIDTH-1:0] REG_LIMIT =
    AXI_ADDR_WIDTH'(NUM_REGS);

  typedef logic [AXI_ADDR_WIDTH-1:0] idx_t;

  function automatic logic idx_ok(input idx_t idx);
    return !ADDR_CHECK || (idx < REG_LIMIT);
  endfunction

  // ---------------- write channel ----------------
  logic [1:0] wr_state;
  logic       aw_held;
  logic       w_held;
  logic       wr_ok;
  logic       aw_hs;
  logic       w_hs;
  logic       w_go;
  idx_t       aw_idx_in;
  idx_t       wr_idx_nxt;

  assign aw_idx_in = s_axil_awaddr >> ADDR_LSB;

  // Readies are gated by rst so they are low during reset and
  // come up in the very first cycle after it is released.
  assign s_axil_awready = !rst && (wr_state == W_COLLECT)
                          && !aw_held;
  assign s_axil_wready  = !rst && (wr_state == W_COLLECT)
                          && !w_held;

  assign aw_hs = s_axil_awvalid && s_axil_awready;
  assign w_hs  = s_axil_wvalid && s_axil_wready;

  // Index the write will use: a same-cycle AW wins over the
  // (not yet valid) held register.
  assign wr_idx_nxt = aw_hs ? aw_idx_in : reg_wr_addr;
  assign w_go = (aw_held || aw_hs) && (w_held || w_hs);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state      <= W_COLLECT;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      wr_ok         <= 1'b0;
      reg_wr_en     <= 1'b0;
      reg_wr_addr   <= '0;
      reg_wr_data   <= '0;
      s_axil_bvalid <= 1'b0;
      s_axil_bresp  <= RESP_OKAY;
    end else begin
      unique case (wr_state)
        W_COLLECT: begin
          if (aw_hs) begin
            reg_wr_addr <= aw_idx_in;
            aw_held     <= 1'b1;
          end
          if (w_hs) begin
            reg_wr_data <= s_axil_wdata;
            w_held      <= 1'b1;
          end
          if (w_go) begin
            wr_ok     <= idx_ok(wr_idx_nxt);
            reg_wr_en <= idx_ok(wr_idx_nxt);
            wr_state  <= W_ISSUE;
          end
        end
        W_ISSUE: begin
          reg_wr_en     <= 1'b0;
          s_axil_bvalid <= 1'b1;
          s_axil_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
          wr_state      <= W_RESP;
        end
        W_RESP: begin
          if (s_axil_bready) begin
            s_axil_bvalid <= 1'b0;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            wr_state      <= W_COLLECT;
          end
        end
        default: begin
          wr_state <= W_COLLECT;
        end
      endcase
    end
  end

  // ---------------- read channel ----------------
  logic [1:0] rd_state;
  logic       rd_ok;
  logic       ar_hs;
  idx_t       ar_idx_in;

  assign ar_idx_in      = s_axil_araddr >> ADDR_LSB;
  assign s_axil_arready = !rst && (rd_state == R_IDLE);
  assign ar_hs          = s_axil_arvalid && s_axil_arready;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state      <= R_IDLE;
      rd_ok         <= 1'b0;
      reg_rd_en     <= 1'b0;
      reg_rd_addr   <= '0;
      s_axil_rvalid <= 1'b0;
      s_axil_rresp  <= RESP_OKAY;
      s_axil_rdata  <= '0;
    end else begin
      unique case (rd_state)
        R_IDLE: begin
          if (ar_hs) begin
            reg_rd_addr <= ar_idx_in;
            rd_ok       <= idx_ok(ar_idx_in);
            reg_rd_en   <= idx_ok(ar_idx_in);
            rd_state    <= R_ISSUE;
          end
        end
        R_ISSUE: begin
          reg_rd_en <= 1'b0;
          rd_state  <= R_CAPTURE;
        end
        R_CAPTURE: begin
          // reg_rd_data is valid now, one clock after the strobe.
          s_axil_rdata  <= rd_ok ? reg_rd_data : '0;
          s_axil_rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
          s_axil_rvalid <= 1'b1;
          rd_state      <= R_RESP;
        end
        R_RESP: begin
          if (s_axil_rready) begin
            s_axil_rvalid <= 1'b0;
            rd_state      <= R_IDLE;
          end
        end
        default: begin
          rd_state <= R_IDLE;
        end
      endcase
    end
  end

  // Writes are always full-word; strobes carry no information.
  logic unused_ok;
  assign unused_ok = ^s_axil_wstrb;

endmodule

// File: tb/tb_axil_reg_bridge.sv
// tb_axil_reg_bridge: directed + random bench for axil_reg_bridge.
// Register stub behind the port, array reference model of contents.
module tb_axil_reg_bridge;

`ifdef AXIL_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int NR = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        reg_wr_en;
  logic [31:0] reg_wr_addr;
  logic [31:0] reg_wr_data;
  logic        reg_rd_en;
  logic [31:0] reg_rd_addr;
  logic [31:0] reg_rd_data;

  always #5 clk = ~clk;

  axil_reg_bridge #(
    .AXI_ADDR_WIDTH(32),
    .AXI_DATA_WIDTH(32),
    .NUM_REGS(NR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_axil_awaddr(awaddr),
    .s_axil_awvalid(awvalid),
    .s_axil_awready(awready),
    .s_axil_wdata(wdata),
    .s_axil_wstrb(wstrb),
    .s_axil_wvalid(wvalid),
    .s_axil_wready(wready),
    .s_axil_bresp(bresp),
    .s_axil_bvalid(bvalid),
    .s_axil_bready(bready),
    .s_axil_araddr(araddr),
    .s_axil_arvalid(arvalid),
    .s_axil_arready(arready),
    .s_axil_rdata(rdata),
    .s_axil_rresp(rresp),
    .s_axil_rvalid(rvalid),
    .s_axil_rready(rready),
    .reg_wr_en(reg_wr_en),
    .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data),
    .reg_rd_en(reg_rd_en),
    .reg_rd_addr(reg_rd_addr),
    .reg_rd_data(reg_rd_data)
  );

  // Register file stub: 1-clock read latency, read-before-write.
  logic [31:0] stub [0:63];
  always_ff @(posedge clk) begin
    if (reg_wr_en) stub[reg_wr_addr[5:0]] <= reg_wr_data;
    if (reg_rd_en) reg_rd_data <= stub[reg_rd_addr[5:0]];
  end

  // Port monitor: strobe counts, last payloads, cycle stamps.
  int          cyc = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          wr_cyc = -1;
  int          rd_cyc = -1;
  int          b_cyc = -1;
  int          r_cyc = -1;
  logic [31:0] wr_a = '0;
  logic [31:0] wr_d = '0;
  logic [31:0] rd_a = '0;
  logic        b_prev = 1'b0;
  logic        r_prev = 1'b0;

  always_ff @(posedge clk) begin
    cyc    <= cyc + 1;
    b_prev <= bvalid;
    r_prev <= rvalid;
    if (bvalid && !b_prev) b_cyc <= cyc;
    if (rvalid && !r_prev) r_cyc <= cyc;
    if (reg_wr_en) begin
      wr_cnt <= wr_cnt + 1;
      wr_cyc <= cyc;
      wr_a   <= reg_wr_addr;
      wr_d   <= reg_wr_data;
    end
    if (reg_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      rd_cyc <= cyc;
      rd_a   <= reg_rd_addr;
    end
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mdl [0:63];

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit ok(input logic [31:0] idx);
    return !CHK || (idx < NR);
  endfunction

  task automatic put_aw_w(input logic [31:0] a, input logic [31:0] d,
                          output int hs);
    int n = 0;
    awaddr = a; wdata = d; wstrb = 4'($urandom);
    awvalid = 1'b1; wvalid = 1'b1;
    while (!(awready && wready) && n < 50) begin tick(); n++; end
    check("aw_w_ready_wait", n < 50, 1);
    hs = cyc;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic put_ar(input logic [31:0] a, output int hs);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    while (!arready && n < 50) begin tick(); n++; end
    check("ar_ready_wait", n < 50, 1);
    hs = cyc;
    tick();
    arvalid = 1'b0;
  endtask

  task automatic take_b(input logic [1:0] er, input int hold);
    int n = 0;
    bit stable = 1'b1;
    logic [1:0] r0;
    bready = 1'b0;
    while (!bvalid && n < 50) begin tick(); n++; end
    check("b_valid_wait", n < 50, 1);
    check("bresp", bresp, er);
    r0 = bresp;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (!bvalid || bresp !== r0 || awready || wready) stable = 1'b0;
    end
    if (hold > 0) check("b_backpressure", stable, 1);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("b_release", bvalid, 0);
  endtask

  task automatic take_r(input logic [31:0] ed, input logic [1:0] er,
                        input int hold);
    int n = 0;
    bit stable = 1'b1;
    logic [31:0] d0;
    rready = 1'b0;
    while (!rvalid && n < 50) begin tick(); n++; end
    check("r_valid_wait", n < 50, 1);
    check("rdata", rdata, ed);
    check("rresp", rresp, er);
    d0 = rdata;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (!rvalid || rdata !== d0 || rresp !== er || arready)
        stable = 1'b0;
    end
    if (hold > 0) check("r_backpressure", stable, 1);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("r_release", rvalid, 0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input int hold);
    int hs;
    int c0 = wr_cnt;
    logic [31:0] idx = a >> 2;
    bit k = ok(idx);
    put_aw_w(a, d, hs);
    take_b(k ? 2'b00 : 2'b10, hold);
    check("wr_strobe_count", wr_cnt - c0, k);
    check("b_latency", b_cyc, hs + 2);
    if (k) begin
      check("wr_latency", wr_cyc, hs + 1);
      check("wr_addr", wr_a, idx);
      check("wr_data", wr_d, d);
      mdl[idx[5:0]] = d;
    end
  endtask

  task automatic do_read(input logic [31:0] a, input int hold);
    int hs;
    int c0 = rd_cnt;
    logic [31:0] idx = a >> 2;
    bit k = ok(idx);
    put_ar(a, hs);
    take_r(k ? mdl[idx[5:0]] : 32'h0, k ? 2'b00 : 2'b10, hold);
    check("rd_strobe_count", rd_cnt - c0, k);
    check("r_latency", r_cyc, hs + 3);
    if (k) begin
      check("rd_latency", rd_cyc, hs + 1);
      check("rd_addr", rd_a, idx);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hs;
    int c0;
    int c1;
    logic [31:0] old;
    for (int i = 0; i < 64; i++) mdl[i] = '0;

    // Reset state
    repeat (3) tick();
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_wr_en", reg_wr_en, 0);
    check("rst_rd_en", reg_rd_en, 0);
    check("rst_readies", {awready, wready, arready}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_resps", {bresp, rresp}, 0);
    check("rst_reg_addrs", {reg_wr_addr, reg_rd_addr}, 0);
    check("rst_reg_wdata", reg_wr_data, 0);
    rst = 1'b0;
    #1;
    check("post_rst_readies", {awready, wready, arready}, 3'b111);

    for (int i = 0; i < 16; i++) do_write(32'(i * 4), $urandom, 0);

    // Same-cycle AW/W
    do_write(32'h08, 32'hDEADBEEF, 0);

    // W three cycles ahead of AW
    c0 = wr_cnt;
    wdata = 32'h1234; wvalid = 1'b1; awaddr = 32'h0C;
    check("w_first_ready", wready, 1);
    tick();
    wvalid = 1'b0;
    check("wready_drop", wready, 0);
    check("awready_hold", awready, 1);
    tick();
    tick();
    check("no_early_strobe", wr_cnt, c0);
    awvalid = 1'b1;
    hs = cyc;
    tick();
    awvalid = 1'b0;
    take_b(2'b00, 0);
    check("wfirst_strobes", wr_cnt - c0, 1);
    check("wfirst_latency", wr_cyc, hs + 1);
    check("wfirst_addr", wr_a, 3);
    check("wfirst_data", wr_d, 32'h1234);
    mdl[3] = 32'h1234;

    // Read with 1-clock stub latency
    do_write(32'h14, 32'hA5A5A5A5, 0);
    do_read(32'h14, 0);

    // Same-index read+write in one cycle, then 10-cycle backpressure
    old = mdl[5];
    awaddr = 32'h14; wdata = 32'h5A5A0000; araddr = 32'h14;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    check("concurrent_ready", {awready, wready, arready}, 3'b111);
    hs = cyc;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    take_b(2'b00, 10);
    take_r(old, 2'b00, 10);
    check("concurrent_wr_cyc", wr_cyc, hs + 1);
    check("concurrent_rd_cyc", rd_cyc, hs + 1);
    mdl[5] = 32'h5A5A0000;
    do_read(32'h14, 0);

    // Index 8 (range boundary) and upper address bits
    do_write(32'h20, 32'hCAFEF00D, 2);
    do_read(32'h20, 2);
    do_write(32'h8000_0044, 32'h0BAD_CAFE, 0);
    do_read(32'h8000_0046, 0);

    // Random mix against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, $urandom_range(0, 3));
      else
        do_read(a, $urandom_range(0, 3));
    end

    // Reset with write in W_ISSUE and read in R_CAPTURE
    araddr = 32'hA4; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    awaddr = 32'hA0; wdata = 32'h77; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("pre_rst_wr_en", reg_wr_en, ok(32'd40));
    rst = 1'b1;
    tick();
    check("mid_rst_valids", {bvalid, rvalid}, 0);
    check("mid_rst_strobes", {reg_wr_en, reg_rd_en}, 0);
    check("mid_rst_readies", {awready, wready, arready}, 0);
    check("mid_rst_rdata", rdata, 0);
    c0 = wr_cnt;
    c1 = rd_cnt;
    rst = 1'b0;
    #1;
    check("mid_rst_release", {awready, wready, arready}, 3'b111);
    repeat (4) tick();
    check("no_strobe_after_rst", {wr_cnt - c0, rd_cnt - c1}, 0);
    check("no_valid_after_rst", {bvalid, rvalid}, 0);
    do_write(32'h1C, 32'h600D_0001, 1);
    do_read(32'h1C, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
